soc_system_key_pio: RTL and testbench

Avalon-MM slave input PIO for the DE1-SoC pushbuttons/switches. It is the read-side counterpart of the LED output PIO on the lightweight HPS bridge. Each input is synchronised, debounced and edge-detected. Edges are latched per bit and raise a maskable level interrupt to the HPS.

---
 rtl/soc_system_pio_pkg.sv | 15 +
 rtl/soc_system_pio_debounce.sv | 59 +++++
 rtl/soc_system_key_pio.sv | 77 +++++++
 tb/tb_soc_system_key_pio.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_system_pio_pkg.sv
// Shared register addresses and edge-type encodings for the input PIO.
// Latency: none (package only).
// Backpressure: none (package only).
package soc_system_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/soc_system_pio_debounce.sv
// One input bit: 2-flop synchroniser, stable-count debounce, edge detect.
// Latency: DEBOUNCE_CYCLES+2 clocks from pin change to deb, edge_pulse one clock after.
// Backpressure: none; free-running per clock.
module soc_system_pio_debounce
    import soc_system_pio_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = 250000,
    parameter int   EDGE_TYPE       = EDGE_FALLING,
    parameter logic IDLE_BIT        = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin,
    output logic deb,
    output logic edge_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_1;
    logic             sync_2;
    logic             deb_d;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_1 <= IDLE_BIT;
            sync_2 <= IDLE_BIT;
            deb    <= IDLE_BIT;
            deb_d  <= IDLE_BIT;
            cnt    <= '0;
        end else begin
            sync_1 <= pin;
            sync_2 <= sync_1;
            deb_d  <= deb;
            // Any return to the accepted level restarts the stability window.
            if (sync_2 == deb) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                deb <= sync_2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    generate
        if (EDGE_TYPE == EDGE_RISING) begin : g_rise
            assign edge_pulse = deb & ~deb_d;
        end else if (EDGE_TYPE == EDGE_FALLING) begin : g_fall
            assign edge_pulse = ~deb & deb_d;
        end else begin : g_any
            assign edge_pulse = deb ^ deb_d;
        end
    endgenerate

endmodule

// File: rtl/soc_system_key_pio.sv
// Avalon-MM input PIO: debounced DATA, IRQMASK, W1C EDGECAPTURE, level irq.
// Latency: zero-wait-state combinational reads; register writes take effect next clock.
// Backpressure: none; slave always ready.
module soc_system_key_pio
    import soc_system_pio_pkg::*;
#(
    parameter int               WIDTH           = 4,
    parameter int               DEBOUNCE_CYCLES = 250000,
    parameter int               EDGE_TYPE       = 1,
    parameter logic [WIDTH-1:0] IDLE_VALUE      = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] edge_pulse;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecapture;
    logic [WIDTH-1:0] clr_mask;
    logic             wr_en;
    logic             unused_wdata;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            soc_system_pio_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .EDGE_TYPE       (EDGE_TYPE),
                .IDLE_BIT        (IDLE_VALUE[i])
            ) u_deb (
                .clk        (clk),
                .reset_n    (reset_n),
                .pin        (in_port[i]),
                .deb        (deb[i]),
                .edge_pulse (edge_pulse[i])
            );
        end
    endgenerate

    assign wr_en        = chipselect & ~write_n;
    assign clr_mask     = (wr_en && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;
    assign unused_wdata = ^writedata;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            irqmask     <= '0;
            edgecapture <= '0;
        end else begin
            if (wr_en && address == ADDR_IRQMASK) begin
                irqmask <= writedata[WIDTH-1:0];
            end
            // OR-ing the new edge after the clear keeps a coincident event.
            edgecapture <= (edgecapture & ~clr_mask) | edge_pulse;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:    readdata[WIDTH-1:0] = deb;
            ADDR_IRQMASK: readdata[WIDTH-1:0] = irqmask;
            ADDR_EDGECAP: readdata[WIDTH-1:0] = edgecapture;
            default:      readdata = '0;
        endcase
    end

    assign irq = |(edgecapture & irqmask);

endmodule

// File: tb/tb_soc_system_key_pio.sv
// Directed bench for soc_system_key_pio with WIDTH=4, DEBOUNCE_CYCLES=4, falling edges.
module tb_soc_system_key_pio;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    int checks;
    int errors;

    soc_system_key_pio #(
        .WIDTH           (4),
        .DEBOUNCE_CYCLES (4),
        .EDGE_TYPE       (1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_addr(input logic [1:0] a);
        address = a;
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        set_addr(2'd0);
        checks++;
        if (readdata !== 32'h0000000F) begin
            errors++;
            $display("FAIL reset_data got %h want %h", readdata, 32'h0000000F);
        end
        set_addr(2'd1);
        checks++;
        if (readdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rsvd got %h want %h", readdata, 32'h0);
        end
        set_addr(2'd2);
        checks++;
        if (readdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_mask got %h want %h", readdata, 32'h0);
        end
        set_addr(2'd3);
        checks++;
        if (readdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_edgecap got %h want %h", readdata, 32'h0);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq got %b want %b", irq, 1'b0);
        end
    endtask

    task automatic test_debounce_latency;
        in_port[0] = 1'b0;
        tick(5);
        set_addr(2'd0);
        checks++;
        if (readdata !== 32'hF) begin
            errors++;
            $display("FAIL lat_early got %h want %h", readdata, 32'hF);
        end
        tick(1);
        set_addr(2'd0);
        checks++;
        if (readdata !== 32'hE) begin
            errors++;
            $display("FAIL lat_data got %h want %h", readdata, 32'hE);
        end
        set_addr(2'd3);
        checks++;
        if (readdata !== 32'h0) begin
            errors++;
            $display("FAIL lat_ec_early got %h want %h", readdata, 32'h0);
        end
        tick(1);
        set_addr(2'd3);
        checks++;
        if (readdata !== 32'h1) begin
            errors++;
            $display("FAIL lat_ec got %h want %h", readdata, 32'h1);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL lat_irq_masked got %b want %b", irq, 1'b0);
        end
    endtask

    task automatic test_glitch;
        in_port[1] = 1'b0;
        tick(3);
        in_port[1] = 1'b1;
        tick(8);
        set_addr(2'd0);
        checks++;
        if (readdata !== 32'hE) begin
            errors++;
            $display("FAIL glitch_data got %h want %h", readdata, 32'hE);
        end
        set_addr(2'd3);
        checks++;
        if (readdata !== 32'h1) begin
            errors++;
            $display("FAIL glitch_ec got %h want %h", readdata, 32'h1);
        end
        in_port[1] = 1'b0;
        tick(5);
        set_addr(2'd0);
        checks++;
        if (readdata !== 32'hE) begin
            errors++;
            $display("FAIL held_early got %h want %h", readdata, 32'hE);
        end
        tick(1);
        set_addr(2'd0);
        checks++;
        if (readdata !== 32'hC) begin
            errors++;
            $display("FAIL held_data got %h want %h", readdata, 32'hC);
        end
        tick(1);
        set_addr(2'd3);
        checks++;
        if (readdata !== 32'h3) begin
            errors++;
            $display("FAIL held_ec got %h want %h", readdata, 32'h3);
        end
    endtask

    task automatic test_irq_mask;
        bus_write(2'd0, 32'h5);
        set_addr(2'd0);
        checks++;
        if (readdata !== 32'hC) begin
            errors++;
            $display("FAIL data_wr_ignored got %h want %h", readdata, 32'hC);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_pre_mask got %b want %b", irq, 1'b0);
        end
        bus_write(2'd2, 32'h1);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_mask_on got %b want %b", irq, 1'b1);
        end
        set_addr(2'd2);
        checks++;
        if (readdata !== 32'h1) begin
            errors++;
            $display("FAIL mask_rd got %h want %h", readdata, 32'h1);
        end
        bus_write(2'd3, 32'h1);
        set_addr(2'd3);
        checks++;
        if (readdata !== 32'h2) begin
            errors++;
            $display("FAIL w1c_bit0 got %h want %h", readdata, 32'h2);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_after_clr got %b want %b", irq, 1'b0);
        end
        bus_write(2'd3, 32'h2);
        set_addr(2'd3);
        checks++;
        if (readdata !== 32'h0) begin
            errors++;
            $display("FAIL w1c_bit1 got %h want %h", readdata, 32'h0);
        end
    endtask

    task automatic test_set_wins;
        in_port[2] = 1'b0;
        tick(6);
        bus_write(2'd3, 32'h4);
        set_addr(2'd3);
        checks++;
        if (readdata !== 32'h4) begin
            errors++;
            $display("FAIL set_wins got %h want %h", readdata, 32'h4);
        end
        bus_write(2'd3, 32'h4);
        bus_write(2'd3, 32'hF);
        set_addr(2'd3);
        checks++;
        if (readdata !== 32'h0) begin
            errors++;
            $display("FAIL w1c_idle got %h want %h", readdata, 32'h0);
        end
        set_addr(2'd0);
        checks++;
        if (readdata !== 32'h8) begin
            errors++;
            $display("FAIL data_after_w1c got %h want %h", readdata, 32'h8);
        end
    endtask

    task automatic test_reset_mid_debounce;
        in_port = 4'hF;
        tick(10);
        set_addr(2'd3);
        checks++;
        if (readdata !== 32'h0) begin
            errors++;
            $display("FAIL rise_not_captured got %h want %h", readdata, 32'h0);
        end
        in_port[3] = 1'b0;
        tick(4);
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        set_addr(2'd0);
        checks++;
        if (readdata !== 32'hF) begin
            errors++;
            $display("FAIL rst_mid_data got %h want %h", readdata, 32'hF);
        end
        set_addr(2'd3);
        checks++;
        if (readdata !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_ec got %h want %h", readdata, 32'h0);
        end
        tick(5);
        set_addr(2'd0);
        checks++;
        if (readdata !== 32'hF) begin
            errors++;
            $display("FAIL redeb_early got %h want %h", readdata, 32'hF);
        end
        tick(1);
        set_addr(2'd0);
        checks++;
        if (readdata !== 32'h7) begin
            errors++;
            $display("FAIL redeb_data got %h want %h", readdata, 32'h7);
        end
        tick(1);
        set_addr(2'd3);
        checks++;
        if (readdata !== 32'h8) begin
            errors++;
            $display("FAIL redeb_ec got %h want %h", readdata, 32'h8);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL redeb_irq got %b want %b", irq, 1'b0);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        in_port    = 4'hF;
        test_reset;
        test_debounce_latency;
        test_glitch;
        test_irq_mask;
        test_set_wins;
        test_reset_mid_debounce;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
